// File: rtl/sw_sig_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sw_sig_pkg
// Description : Shared types and constants for the software-signal arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sw_sig_pkg;

    localparam int unsigned NUM_REQ   = 3;
    localparam int unsigned CODE_W    = 2;
    localparam logic [1:0]  CODE_IDLE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POST  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Requester index reached by stepping 'off' places past 'base', wrapping at NUM_REQ.
    function automatic logic [CODE_W-1:0] rr_next(input logic [CODE_W-1:0] base,
                                                  input int unsigned       off);
        int unsigned s;
        s = (32'(base) + off) % NUM_REQ;
        return CODE_W'(s);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_sig_if.sv
`default_nettype none
// ============================================================================
// Module      : sw_sig_if
// Description : Request/done and software PIO handshake bundle for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface sw_sig_if;
    import sw_sig_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [CODE_W-1:0]  to_sw_sig;
    logic               to_hw_ack;
    logic               busy;
    logic               timeout_err;

    modport master (
        output req, to_hw_ack,
        input  done, to_sw_sig, busy, timeout_err
    );

    modport slave (
        input  req, to_hw_ack,
        output done, to_sw_sig, busy, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/sw_sig_sync.sv
`default_nettype none
// ============================================================================
// Module      : sw_sig_sync
// Description : STAGES-deep flop chain bringing the software ack into clk.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_sig_sync #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic async_i,
    output logic      sync_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];
endmodule
`default_nettype wire

// File: rtl/sw_sig_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sw_sig_arbiter
// Description : Round-robin arbiter posting requester events to software via a
//               4-phase PIO handshake. Optional POST ack timeout: SW_SIG_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_sig_arbiter
    import sw_sig_pkg::*;
#(
    parameter int          SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  wire logic  clk,
    input  wire logic  reset_n,
    sw_sig_if.slave    bus
);
    localparam int c_PRIME_W = $clog2(SYNC_STAGES + 1);

    state_e                state_q, state_d;
    logic [CODE_W-1:0]     grant_q, grant_d;
    logic [CODE_W-1:0]     last_q, last_d;
    logic [CODE_W-1:0]     code_q, code_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic                  tmo_d;
    logic [c_PRIME_W-1:0]  prime_q;
    logic                  w_primed;
    logic                  w_ack_s;
    logic                  w_found;
    logic [CODE_W-1:0]     w_pick;

    sw_sig_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (bus.to_hw_ack),
        .sync_o  (w_ack_s)
    );

    // The synchronizer leaves reset at 0 regardless of the real ack level, so
    // grants are held off until the chain has refilled from the live input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_q <= '0;
        end else if (!w_primed) begin
            prime_q <= prime_q + c_PRIME_W'(1);
        end
    end
    assign w_primed = (prime_q == c_PRIME_W'(SYNC_STAGES));

    always_comb begin
        w_found = 1'b0;
        w_pick  = last_q;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            if (!w_found && bus.req[rr_next(last_q, i)]) begin
                w_found = 1'b1;
                w_pick  = rr_next(last_q, i);
            end
        end
    end

`ifdef SW_SIG_TIMEOUT_EN
    localparam int                c_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] cnt_q;
    logic               aborted_q;
    logic               tmo_q;

    // POST is only entered from IDLE, so clearing in IDLE resets it on every entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            aborted_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            if (state_q == ST_IDLE) begin
                cnt_q     <= '0;
                aborted_q <= 1'b0;
            end else begin
                if (state_q == ST_POST) cnt_q <= cnt_q + c_CNT_W'(1);
                if (tmo_d)              aborted_q <= 1'b1;
            end
        end
    end
    assign bus.timeout_err = tmo_q;
`else
    localparam int unsigned c_tmo_unused = TIMEOUT_CYCLES;
    assign bus.timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        code_d  = code_q;
        done_d  = '0;
        tmo_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_primed && !w_ack_s && w_found) begin
                    grant_d = w_pick;
                    code_d  = w_pick + CODE_W'(1);
                    state_d = ST_POST;
                end
            end
            ST_POST: begin
                if (w_ack_s) begin
                    code_d  = CODE_IDLE;
                    state_d = ST_CLEAR;
                end
`ifdef SW_SIG_TIMEOUT_EN
                else if (cnt_q == c_CNT_MAX) begin
                    code_d  = CODE_IDLE;
                    tmo_d   = 1'b1;
                    last_d  = grant_q;
                    state_d = ST_CLEAR;
                end
`endif
            end
            ST_CLEAR: begin
                if (!w_ack_s) state_d = ST_DONE;
            end
            ST_DONE: begin
`ifdef SW_SIG_TIMEOUT_EN
                if (!aborted_q) done_d = NUM_REQ'(1) << grant_q;
`else
                done_d = NUM_REQ'(1) << grant_q;
`endif
                last_d  = grant_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= CODE_W'(NUM_REQ - 1);
            code_q  <= CODE_IDLE;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            code_q  <= code_d;
            done_q  <= done_d;
        end
    end

    assign bus.to_sw_sig = code_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_sw_sig_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_sig_arbiter
// Description : Directed self-checking bench for sw_sig_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_sig_arbiter;
    localparam int S = 2;

    logic clk;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    sw_sig_if bus();

    sw_sig_arbiter #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(20)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(S + 1);
    endtask

    task automatic test_reset();
        bus.req = 3'b000; bus.to_hw_ack = 1'b0; reset_n = 1'b0;
        tick(2);
        tests++; if (bus.to_sw_sig !== 2'd0) begin fails++; $display("FAIL reset_code: got %0d want 0", bus.to_sw_sig); end
        tests++; if (bus.done !== 3'b000) begin fails++; $display("FAIL reset_done: got %b want 000", bus.done); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tests++; if (bus.timeout_err !== 1'b0) begin fails++; $display("FAIL reset_tmo: got %b want 0", bus.timeout_err); end
        reset_n = 1'b1;
        tick(S + 1);
        tests++; if (bus.busy !== 1'b0 || bus.to_sw_sig !== 2'd0) begin fails++; $display("FAIL post_reset_idle: busy %b code %0d want 0 0", bus.busy, bus.to_sw_sig); end
    endtask

    task automatic test_single();
        bus.req = 3'b010;
        tick(1);
        tests++; if (bus.to_sw_sig !== 2'd2 || bus.busy !== 1'b1) begin fails++; $display("FAIL single_post: code %0d busy %b want 2 1", bus.to_sw_sig, bus.busy); end
        tick(5);
        tests++; if (bus.to_sw_sig !== 2'd2) begin fails++; $display("FAIL single_hold: got %0d want 2", bus.to_sw_sig); end
        bus.to_hw_ack = 1'b1;
        tick(S);
        tests++; if (bus.to_sw_sig !== 2'd2) begin fails++; $display("FAIL single_sync_lat: got %0d want 2", bus.to_sw_sig); end
        tick(1);
        tests++; if (bus.to_sw_sig !== 2'd0) begin fails++; $display("FAIL single_clear: got %0d want 0", bus.to_sw_sig); end
        bus.to_hw_ack = 1'b0;
        tick(S + 1);
        tests++; if (bus.done !== 3'b000) begin fails++; $display("FAIL single_early_done: got %b want 000", bus.done); end
        tick(1);
        tests++; if (bus.done !== 3'b010) begin fails++; $display("FAIL single_done: got %b want 010", bus.done); end
        bus.req = 3'b000;
        tick(1);
        tests++; if (bus.done !== 3'b000 || bus.busy !== 1'b0) begin fails++; $display("FAIL single_after: done %b busy %b want 000 0", bus.done, bus.busy); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_code [4];
        logic [2:0] exp_done [4];
        exp_code = '{2'd1, 2'd2, 2'd3, 2'd1};
        exp_done = '{3'b001, 3'b010, 3'b100, 3'b001};
        do_reset();
        bus.req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            tests++; if (bus.to_sw_sig !== exp_code[k]) begin fails++; $display("FAIL rr_code[%0d]: got %0d want %0d", k, bus.to_sw_sig, exp_code[k]); end
            bus.to_hw_ack = 1'b1;
            tick(S + 1);
            tests++; if (bus.to_sw_sig !== 2'd0) begin fails++; $display("FAIL rr_clear[%0d]: got %0d want 0", k, bus.to_sw_sig); end
            bus.to_hw_ack = 1'b0;
            tick(S + 2);
            tests++; if (bus.done !== exp_done[k]) begin fails++; $display("FAIL rr_done[%0d]: got %b want %b", k, bus.done, exp_done[k]); end
        end
        bus.req = 3'b000;
        tick(2);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rr_idle: got %b want 0", bus.busy); end
    endtask

    task automatic test_stale_ack();
        bus.to_hw_ack = 1'b1;
        bus.req = 3'b001;
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(5);
        tests++; if (bus.to_sw_sig !== 2'd0 || bus.busy !== 1'b0) begin fails++; $display("FAIL stale_hold: code %0d busy %b want 0 0", bus.to_sw_sig, bus.busy); end
        bus.to_hw_ack = 1'b0;
        tick(S);
        tests++; if (bus.to_sw_sig !== 2'd0) begin fails++; $display("FAIL stale_early: got %0d want 0", bus.to_sw_sig); end
        tick(1);
        tests++; if (bus.to_sw_sig !== 2'd1) begin fails++; $display("FAIL stale_grant: got %0d want 1", bus.to_sw_sig); end
        bus.to_hw_ack = 1'b1;
        tick(S + 1);
        bus.to_hw_ack = 1'b0;
        tick(S + 2);
        tests++; if (bus.done !== 3'b001) begin fails++; $display("FAIL stale_done: got %b want 001", bus.done); end
        bus.req = 3'b000;
        tick(1);
    endtask

    task automatic test_req_withdrawn();
        do_reset();
        bus.req = 3'b001;
        tick(1);
        tests++; if (bus.to_sw_sig !== 2'd1) begin fails++; $display("FAIL wd_grant: got %0d want 1", bus.to_sw_sig); end
        tick(2);
        bus.req = 3'b000;
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL wd_busy: got %b want 1", bus.busy); end
        bus.to_hw_ack = 1'b1;
        tick(S + 1);
        tests++; if (bus.to_sw_sig !== 2'd0) begin fails++; $display("FAIL wd_clear: got %0d want 0", bus.to_sw_sig); end
        bus.to_hw_ack = 1'b0;
        tick(S + 1);
        tests++; if (bus.done !== 3'b000) begin fails++; $display("FAIL wd_early_done: got %b want 000", bus.done); end
        tick(1);
        tests++; if (bus.done !== 3'b001) begin fails++; $display("FAIL wd_done: got %b want 001", bus.done); end
        tick(1);
        tests++; if (bus.done !== 3'b000 || bus.busy !== 1'b0) begin fails++; $display("FAIL wd_after: done %b busy %b want 000 0", bus.done, bus.busy); end
    endtask

    task automatic test_reset_mid_post();
        do_reset();
        bus.req = 3'b011;
        tick(1);
        bus.to_hw_ack = 1'b1;
        tick(S + 1);
        bus.to_hw_ack = 1'b0;
        tick(S + 2);
        tests++; if (bus.done !== 3'b001) begin fails++; $display("FAIL rmp_first_done: got %b want 001", bus.done); end
        tick(1);
        tests++; if (bus.to_sw_sig !== 2'd2) begin fails++; $display("FAIL rmp_second_grant: got %0d want 2", bus.to_sw_sig); end
        tick(2);
        reset_n = 1'b0;
        #1;
        tests++; if (bus.to_sw_sig !== 2'd0 || bus.busy !== 1'b0) begin fails++; $display("FAIL rmp_async: code %0d busy %b want 0 0", bus.to_sw_sig, bus.busy); end
        for (int k = 0; k < 3; k++) begin
            tick(1);
            tests++; if (bus.done !== 3'b000) begin fails++; $display("FAIL rmp_no_done[%0d]: got %b want 000", k, bus.done); end
        end
        reset_n = 1'b1;
        tick(S);
        tests++; if (bus.to_sw_sig !== 2'd0 || bus.done !== 3'b000) begin fails++; $display("FAIL rmp_release: code %0d done %b want 0 000", bus.to_sw_sig, bus.done); end
        tick(1);
        tests++; if (bus.to_sw_sig !== 2'd1) begin fails++; $display("FAIL rmp_regrant: got %0d want 1", bus.to_sw_sig); end
        bus.req = 3'b000;
        bus.to_hw_ack = 1'b1;
        tick(S + 1);
        bus.to_hw_ack = 1'b0;
        tick(S + 2);
        tests++; if (bus.done !== 3'b001) begin fails++; $display("FAIL rmp_done: got %b want 001", bus.done); end
        tick(1);
    endtask

    task automatic test_timeout();
        do_reset();
`ifdef SW_SIG_TIMEOUT_EN
        bus.req = 3'b011;
        tick(1);
        tests++; if (bus.to_sw_sig !== 2'd1) begin fails++; $display("FAIL tmo_grant: got %0d want 1", bus.to_sw_sig); end
        tick(19);
        tests++; if (bus.to_sw_sig !== 2'd1 || bus.timeout_err !== 1'b0) begin fails++; $display("FAIL tmo_early: code %0d tmo %b want 1 0", bus.to_sw_sig, bus.timeout_err); end
        tick(1);
        tests++; if (bus.to_sw_sig !== 2'd0 || bus.timeout_err !== 1'b1) begin fails++; $display("FAIL tmo_fire: code %0d tmo %b want 0 1", bus.to_sw_sig, bus.timeout_err); end
        tick(1);
        tests++; if (bus.timeout_err !== 1'b0) begin fails++; $display("FAIL tmo_pulse: got %b want 0", bus.timeout_err); end
        tick(1);
        tests++; if (bus.done !== 3'b000 || bus.busy !== 1'b0) begin fails++; $display("FAIL tmo_no_done: done %b busy %b want 000 0", bus.done, bus.busy); end
        tick(1);
        tests++; if (bus.to_sw_sig !== 2'd2) begin fails++; $display("FAIL tmo_next: got %0d want 2", bus.to_sw_sig); end
        bus.req = 3'b000;
        bus.to_hw_ack = 1'b1;
        tick(S + 1);
        bus.to_hw_ack = 1'b0;
        tick(S + 2);
        tests++; if (bus.done !== 3'b010) begin fails++; $display("FAIL tmo_next_done: got %b want 010", bus.done); end
`else
        bus.req = 3'b001;
        for (int k = 0; k < 30; k++) begin
            tick(1);
            tests++; if (bus.timeout_err !== 1'b0) begin fails++; $display("FAIL no_tmo[%0d]: got %b want 0", k, bus.timeout_err); end
        end
        tests++; if (bus.to_sw_sig !== 2'd1 || bus.busy !== 1'b1) begin fails++; $display("FAIL no_tmo_wait: code %0d busy %b want 1 1", bus.to_sw_sig, bus.busy); end
        bus.req = 3'b000;
        bus.to_hw_ack = 1'b1;
        tick(S + 1);
        bus.to_hw_ack = 1'b0;
        tick(S + 2);
        tests++; if (bus.done !== 3'b001) begin fails++; $display("FAIL no_tmo_done: got %b want 001", bus.done); end
`endif
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = 3'b000;
        bus.to_hw_ack = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_stale_ack();
        test_req_withdrawn();
        test_reset_mid_post();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sw_sig_arbiter.md
SW_SIG_ARBITER -- requirements
Module: sw_sig_arbiter

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on to_hw_ack; legal values are 2 to 4.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000000: POST-state ack timeout, in clk cycles; used only under SW_SIG_TIMEOUT_EN.
REQ-003 clk  input  1  system clock; all logic is rising-edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  3  per-requester level request; held high until the matching done bit pulses.
REQ-006 done  output  3  one-cycle completion pulse per requester.
REQ-007 to_sw_sig  output  2  event code to the software-readable input PIO; 0 means idle, 1..3 means requester index+1.
REQ-008 to_hw_ack  input  1  software acknowledge from the output PIO; asynchronous to clk.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 timeout_err  output  1  one-cycle pulse on ack timeout; tied to 0 without SW_SIG_TIMEOUT_EN.

Function
REQ-011 The block shall run a 4-phase handshake FSM with states IDLE, POST, CLEAR and DONE.
REQ-012 IDLE: when ack_s==0 and any req bit is high, the block shall latch the grant, register to_sw_sig=grant+1 and enter POST on the next edge.
REQ-013 IDLE with ack_s==1 (stale ack): the block shall make no grant until ack_s==0.
REQ-014 POST: on ack_s==1, the block shall drive to_sw_sig=0 and enter CLEAR.
REQ-015 CLEAR: on ack_s==0, the block shall enter DONE.
REQ-016 DONE: the block shall assert done[grant] for exactly one cycle, set last=grant and return to IDLE.
REQ-017 Arbitration shall be round-robin; search order starts at (last+1) mod 3; with req=3'b111 after reset, the grant order is 0,1,2,0.
REQ-018 Once granted, a transaction shall complete even if its req drops; done still pulses.
REQ-019 New req edges during POST, CLEAR or DONE shall not preempt the grant; they are evaluated only in IDLE.
REQ-020 ack_s is to_hw_ack after SYNC_STAGES flops; minimum latency from req high to done is 4 + 2*SYNC_STAGES cycles when software acks instantly.
REQ-021 to_sw_sig, done and timeout_err shall be registered outputs; busy is decoded from state.

Reset
REQ-022 Reset shall force: state=IDLE, to_sw_sig=0, done=0, timeout_err=0, busy=0, last=2 (requester 0 wins first), synchronizer flops=0 and timeout counter=0.
REQ-023 Reset mid-transaction shall abort the transaction with no done pulse; the interrupted requester re-arbitrates normally after release.

Configuration
REQ-024 Macro SW_SIG_TIMEOUT_EN defined: a counter runs in POST; after TIMEOUT_CYCLES cycles without ack_s it shall drive to_sw_sig=0, pulse timeout_err, give no done, set last=grant and enter CLEAR.
REQ-025 Macro SW_SIG_TIMEOUT_EN defined: the counter clears on every entry to POST and is $clog2(TIMEOUT_CYCLES+1) bits wide.
REQ-026 Macro SW_SIG_TIMEOUT_EN undefined: POST waits indefinitely, no counter is synthesized and timeout_err is constant 0.

Structure
REQ-027 Package sw_sig_pkg shall hold the state enum, NUM_REQ=3, CODE_IDLE=2'b00 and the code width constant (2).
REQ-028 Sub-module sw_sig_sync shall implement the parameterized SYNC_STAGES-flop synchronizer with asynchronous active-low reset to 0.
REQ-029 Round-robin select and the FSM shall reside in sw_sig_arbiter.

Verification
REQ-030 Single request: req=3'b010 with software acking after 5 cycles -> to_sw_sig=2, then 0 after ack, then done=3'b010 for one cycle; busy low afterward.
REQ-031 Contention: req=3'b111 held through 4 transactions -> to_sw_sig sequence 1,2,3,1 and done pulses 001,010,100,001.
REQ-032 Stale ack: to_hw_ack=1 at reset release with req=3'b001 -> to_sw_sig stays 0 until ack drops, then 1 after SYNC_STAGES+1 cycles.
REQ-033 Req withdrawn: req[0] drops 2 cycles into POST -> transaction completes and done[0] still pulses.
REQ-034 Reset mid-POST: reset_n low for 3 cycles -> to_sw_sig=0, no done, and requester 0 wins first after release.
REQ-035 SW_SIG_TIMEOUT_EN with TIMEOUT_CYCLES=20 and no ack -> timeout_err pulses in cycle 20 of POST, to_sw_sig=0, no done, and the next grant goes to the next requester.
